ram8_arbiter: RTL and testbench

RAM8_ARBITER -- requirements
Module: ram8_arbiter

---
 rtl/ram8_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram8_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram8_arbiter.sv
// ram8_arbiter
//   Eight-word register file shared by two requesters (A and B). One access,
//   either a read or a write, is performed per cycle. After every reset the
//   array is swept to zero over 8 cycles, with busy high while the sweep runs.
//   When both ports request in the same cycle, the round-robin priority
//   pointer decides which one wins.
//
// Handshake: a requester raises req_x with we_x/addr_x/wdata_x and holds all
//   four stable until it sees gnt_x high in the same cycle. The transfer
//   happens on the rising edge that ends that cycle. The block samples the
//   request fields only in the granted cycle. A granted read returns
//   rdata_x with a one-cycle rvalid_x pulse on the next cycle. rdata_x holds
//   its value while rvalid_x is low.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   busy                high during the post-reset clear sweep (state == CLEAR)
//   req_a, we_a         port A request, write enable (1=write, 0=read)
//   addr_a, wdata_a     port A word select (0..7), write data
//   gnt_a               port A request accepted this cycle (combinational)
//   rvalid_a, rdata_a   port A read data valid pulse, registered read data
//   *_b                 same meaning for port B
module ram8_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic             busy,
   input  logic             req_a,
   input  logic             we_a,
   input  logic [2:0]       addr_a,
   input  logic [WIDTH-1:0] wdata_a,
   output logic             gnt_a,
   output logic             rvalid_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic             req_b,
   input  logic             we_b,
   input  logic [2:0]       addr_b,
   input  logic [WIDTH-1:0] wdata_b,
   output logic             gnt_b,
   output logic             rvalid_b,
   output logic [WIDTH-1:0] rdata_b
);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       cnt_q;
   logic             ptr_q;            // 0: A has priority, 1: B has priority
   logic [WIDTH-1:0] mem [8];

   logic             mem_we;
   logic [2:0]       mem_waddr;
   logic [WIDTH-1:0] mem_wdata;

   // busy decodes the FSM state directly, so it also serves as the state
   // observation point.
   assign busy = (state_q == CLEAR);

   // Grants are gated by reset so that no grant is visible while reset is
   // held, even if the FSM register still reads READY.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!reset && state_q == READY) begin
         gnt_a = req_a && (!req_b || !ptr_q);
         gnt_b = req_b && (!req_a ||  ptr_q);
      end
   end

   // Next-state logic: the sweep ends after word 7 has been cleared.
   always_comb begin
      state_d = state_q;
      if (state_q == CLEAR && cnt_q == 3'd7) begin
         state_d = READY;
      end
   end

   // The single write port is shared by the clear sweep and the granted
   // writes. At most one grant is high, so there is no conflict.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = 3'd0;
      mem_wdata = '0;
      if (!reset) begin
         if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
         end else if (gnt_a && we_a) begin
            mem_we    = 1'b1;
            mem_waddr = addr_a;
            mem_wdata = wdata_a;
         end else if (gnt_b && we_b) begin
            mem_we    = 1'b1;
            mem_waddr = addr_b;
            mem_wdata = wdata_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= CLEAR;
         cnt_q    <= 3'd0;
         ptr_q    <= 1'b0;
         rvalid_a <= 1'b0;
         rvalid_b <= 1'b0;
         rdata_a  <= '0;
         rdata_b  <= '0;
      end else begin
         state_q  <= state_d;
         rvalid_a <= 1'b0;
         rvalid_b <= 1'b0;
         if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 3'd1;
         end
         if (gnt_a) begin
            ptr_q <= 1'b1;
            if (!we_a) begin
               rdata_a  <= mem[addr_a];
               rvalid_a <= 1'b1;
            end
         end else if (gnt_b) begin
            ptr_q <= 1'b0;
            if (!we_b) begin
               rdata_b  <= mem[addr_b];
               rvalid_b <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram8_arbiter.sv
module tb_ram8_arbiter;

   localparam int WIDTH = 16;

   logic             clk;
   logic             reset;
   logic             busy;
   logic             req_a, we_a, gnt_a, rvalid_a;
   logic [2:0]       addr_a;
   logic [WIDTH-1:0] wdata_a, rdata_a;
   logic             req_b, we_b, gnt_b, rvalid_b;
   logic [2:0]       addr_b;
   logic [WIDTH-1:0] wdata_b, rdata_b;

   int n_checks = 0;
   int n_pass   = 0;

   ram8_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .busy(busy),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // advance one clock; sample point is 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // inputs are applied just after an edge; let combinational grants settle
   task automatic settle();
      #1;
   endtask

   task automatic idle_ports();
      req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
      req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
   endtask

   initial begin
      logic [WIDTH-1:0] wvals [4];
      wvals[0] = 16'h0011; wvals[1] = 16'h0022; wvals[2] = 16'h0033; wvals[3] = 16'h0044;

      // reset state
      reset = 1;
      idle_ports();
      step();
      step();
      check("rst_busy", busy, 1);
      check("rst_gnt_a", gnt_a, 0);
      check("rst_gnt_b", gnt_b, 0);
      check("rst_rvalid_a", rvalid_a, 0);
      check("rst_rvalid_b", rvalid_b, 0);
      check("rst_rdata_a", rdata_a, 0);
      check("rst_rdata_b", rdata_b, 0);

      // release with both requesting reads: 8 busy cycles, no grants
      reset = 0;
      req_a = 1; addr_a = 3'd0;
      req_b = 1; addr_b = 3'd1;
      for (int i = 0; i < 8; i++) begin
         settle();
         check($sformatf("clr_busy_%0d", i), busy, 1);
         check($sformatf("clr_gnt_a_%0d", i), gnt_a, 0);
         check($sformatf("clr_gnt_b_%0d", i), gnt_b, 0);
         step();
      end

      // cycle 9 onward: alternating grants A,B,A,B,A,B, never both
      for (int i = 0; i < 6; i++) begin
         settle();
         check($sformatf("rr_busy_%0d", i), busy, 0);
         check($sformatf("rr_gnt_a_%0d", i), gnt_a, (i % 2 == 0) ? 1 : 0);
         check($sformatf("rr_gnt_b_%0d", i), gnt_b, (i % 2 == 1) ? 1 : 0);
         step();
      end
      idle_ports();
      // pointer is now A again (last grant went to B)

      // A reads addr 5 after the clear
      req_a = 1; we_a = 0; addr_a = 3'd5;
      settle();
      check("rd5_gnt_a", gnt_a, 1);
      step();
      idle_ports();
      check("rd5_rvalid_a", rvalid_a, 1);
      check("rd5_rdata_a", rdata_a, 16'h0000);
      step();
      check("rd5_rvalid_pulse", rvalid_a, 0);

      // A writes 0xBEEF to addr 3, then B reads it back the next cycle
      req_a = 1; we_a = 1; addr_a = 3'd3; wdata_a = 16'hBEEF;
      settle();
      check("wr3_gnt_a", gnt_a, 1);
      step();
      idle_ports();
      check("wr3_no_rvalid_a", rvalid_a, 0);
      req_b = 1; we_b = 0; addr_b = 3'd3;
      settle();
      check("raw_gnt_b", gnt_b, 1);
      step();
      idle_ports();
      check("raw_rvalid_b", rvalid_b, 1);
      check("raw_rdata_b", rdata_b, 16'hBEEF);
      step();
      check("raw_rdata_hold", rdata_b, 16'hBEEF);

      // A writes four words back to back, then B reads them back to back
      for (int i = 0; i < 4; i++) begin
         req_a = 1; we_a = 1; addr_a = 3'(i); wdata_a = wvals[i];
         settle();
         check($sformatf("bw_gnt_a_%0d", i), gnt_a, 1);
         step();
      end
      idle_ports();
      for (int i = 0; i < 4; i++) begin
         req_b = 1; we_b = 0; addr_b = 3'(i);
         settle();
         check($sformatf("br_gnt_b_%0d", i), gnt_b, 1);
         step();
         check($sformatf("br_rvalid_b_%0d", i), rvalid_b, 1);
         check($sformatf("br_rdata_b_%0d", i), rdata_b, wvals[i]);
      end
      idle_ports();
      step();
      check("br_rvalid_end", rvalid_b, 0);

      // fill with 0xFFFF, start a read, then reset mid-stream
      for (int i = 0; i < 4; i++) begin
         req_a = 1; we_a = 1; addr_a = 3'(i); wdata_a = 16'hFFFF;
         step();
      end
      req_a = 1; we_a = 0; addr_a = 3'd2;
      settle();
      check("ff_rd_gnt_a", gnt_a, 1);
      step();
      check("ff_rvalid_a", rvalid_a, 1);
      check("ff_rdata_a", rdata_a, 16'hFFFF);
      for (int i = 4; i < 8; i++) begin
         req_a = 1; we_a = 1; addr_a = 3'(i); wdata_a = 16'hFFFF;
         step();
      end
      req_a = 1; we_a = 0; addr_a = 3'd7;
      reset = 1;
      settle();
      check("mid_rst_gnt_a", gnt_a, 0);
      step();
      idle_ports();
      check("mid_rst_rvalid_a", rvalid_a, 0);
      check("mid_rst_rdata_a", rdata_a, 0);
      check("mid_rst_busy", busy, 1);
      reset = 0;
      req_b = 1; addr_b = 3'd4;
      for (int i = 0; i < 8; i++) begin
         settle();
         check($sformatf("sweep_busy_%0d", i), busy, 1);
         check($sformatf("sweep_gnt_b_%0d", i), gnt_b, 0);
         step();
      end
      idle_ports();
      settle();
      check("sweep_done", busy, 0);
      for (int i = 0; i < 8; i++) begin
         req_a = 1; we_a = 0; addr_a = 3'(i);
         step();
         check($sformatf("zero_rvalid_%0d", i), rvalid_a, 1);
         check($sformatf("zero_rdata_%0d", i), rdata_a, 16'h0000);
      end
      idle_ports();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // gnt_a and gnt_b must never be high together
   always @(negedge clk) begin
      if (gnt_a && gnt_b) begin
         n_checks++;
         $display("FAIL dual_grant: got gnt_a=1 gnt_b=1 expected at most one");
      end
   end

endmodule
